// File: rtl/led_scan_pkg.sv
// Shared timing defaults and width helpers for the LED matrix scan blocks.
package led_scan_pkg;

  localparam int unsigned CLK_HZ      = 27_000_000;
  localparam int unsigned DEF_PERIOD  = 27_000;   // 1 ms row dwell at 27 MHz
  localparam int unsigned DEF_GAP_ON  = 100;
  localparam int unsigned DEF_GAP_OFF = 2_000;

  // Dwell counter width; never below one bit.
  function automatic int unsigned cnt_w(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  // Row index width; never below one bit.
  function automatic int unsigned idx_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/led_row_timer.sv
// Row dwell counter, advance strobe and lit window (LED_MATRIX_DIM_EN adds duty trim).
module led_row_timer
  import led_scan_pkg::*;
#(
  parameter int unsigned PERIOD  = DEF_PERIOD,
  parameter int unsigned GAP_ON  = DEF_GAP_ON,
  parameter int unsigned GAP_OFF = DEF_GAP_OFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
`ifdef LED_MATRIX_DIM_EN
  input  logic [7:0] duty,
`endif
  output logic       advance,
  output logic       led_on
);

  localparam int unsigned CW    = cnt_w(PERIOD);
  localparam logic [31:0] LAST  = 32'(PERIOD - 1);
  localparam logic [31:0] ON_LO = 32'(GAP_ON);
  localparam logic [31:0] ON_HI = 32'(PERIOD - GAP_OFF);

  if (GAP_ON + GAP_OFF >= PERIOD) begin : g_chk_gap
    $error("led_row_timer: GAP_ON+GAP_OFF must be below PERIOD");
  end

  logic [CW-1:0] cnt;
  logic [31:0]   cnt32;
  logic          in_win;

  assign cnt32   = 32'(cnt);
  assign advance = en && (cnt32 == LAST);
  assign in_win  = (cnt32 >= ON_LO) && (cnt32 < ON_HI);

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (en)  cnt <= advance ? '0 : cnt + CW'(1);
  end

`ifdef LED_MATRIX_DIM_EN
  localparam logic [31:0] WIN_W = 32'(PERIOD - GAP_ON - GAP_OFF);

  logic [7:0]  duty_q;
  logic [31:0] lit_len;

  // Duty only changes at row boundaries so a row never flickers mid-dwell.
  always_ff @(posedge clk) begin
    if (rst)          duty_q <= '0;
    else if (advance) duty_q <= duty;
  end

  assign lit_len = (WIN_W * 32'(duty_q)) >> 8;
  assign led_on  = en && in_win && ((cnt32 - ON_LO) < lit_len);
`else
  assign led_on  = en && in_win;
`endif

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexed LED matrix driver: per-row column latch and row select decode.
// Optional brightness trim via LED_MATRIX_DIM_EN (adds the duty input).
module led_matrix_scan
  import led_scan_pkg::*;
#(
  parameter int unsigned NUM_ROWS       = 9,
  parameter int unsigned COL_W          = 8,
  parameter int unsigned PERIOD         = DEF_PERIOD,
  parameter int unsigned GAP_ON         = DEF_GAP_ON,
  parameter int unsigned GAP_OFF        = DEF_GAP_OFF,
  parameter bit          ROW_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
`ifdef LED_MATRIX_DIM_EN
  input  logic [7:0]                    duty,
`endif
  input  logic [NUM_ROWS*COL_W-1:0]     pattern,
  output logic [NUM_ROWS-1:0]           led_row,
  output logic [COL_W-1:0]              led_col,
  output logic [idx_w(NUM_ROWS)-1:0]    row_index,
  output logic                          frame_start
);

  localparam int unsigned RW       = idx_w(NUM_ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

  if (NUM_ROWS < 2) begin : g_chk_rows
    $error("led_matrix_scan: NUM_ROWS must be at least 2");
  end
  if (COL_W < 1) begin : g_chk_cols
    $error("led_matrix_scan: COL_W must be at least 1");
  end

  logic          advance;
  logic          led_on;
  logic [RW-1:0] next_row;

  led_row_timer #(
    .PERIOD  (PERIOD),
    .GAP_ON  (GAP_ON),
    .GAP_OFF (GAP_OFF)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
`ifdef LED_MATRIX_DIM_EN
    .duty    (duty),
`endif
    .advance (advance),
    .led_on  (led_on)
  );

  assign next_row = (row_index == LAST_ROW) ? '0 : row_index + RW'(1);

  // Column data is captured for the row about to be shown, so later
  // pattern writes cannot tear the row currently on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_index   <= '0;
      led_col     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= advance && (next_row == '0);
      if (advance) begin
        row_index <= next_row;
        led_col   <= pattern[next_row*COL_W +: COL_W];
      end
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic act;
    assign act        = led_on && (row_index == RW'(r));
    assign led_row[r] = ROW_ACTIVE_LOW ? ~act : act;
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: an elapsed-time reference model feeds a
// queue of expected outputs that a negedge monitor pops and compares.
module tb_led_matrix_scan;

  localparam int NUM_ROWS = 3;
  localparam int COL_W    = 4;
  localparam int PERIOD   = 20;
  localparam int GAP_ON   = 2;
  localparam int GAP_OFF  = 4;
  localparam int PW       = NUM_ROWS * COL_W;
  localparam int FRAME    = PERIOD * NUM_ROWS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b1;
  logic [PW-1:0]     pattern = 12'hCBA;
  logic [NUM_ROWS-1:0] led_row;
  logic [COL_W-1:0]  led_col;
  logic [1:0]        row_index;
  logic              frame_start;
`ifdef LED_MATRIX_DIM_EN
  logic [7:0]        duty = 8'd128;
  int                m_dq;
`endif

  always #5 clk = ~clk;

  led_matrix_scan #(
    .NUM_ROWS       (NUM_ROWS),
    .COL_W          (COL_W),
    .PERIOD         (PERIOD),
    .GAP_ON         (GAP_ON),
    .GAP_OFF        (GAP_OFF),
    .ROW_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
`ifdef LED_MATRIX_DIM_EN
    .duty        (duty),
`endif
    .pattern     (pattern),
    .led_row     (led_row),
    .led_col     (led_col),
    .row_index   (row_index),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [NUM_ROWS-1:0] row;
    logic [COL_W-1:0]    col;
    logic [1:0]          idx;
    logic                fs;
  } exp_t;

  exp_t q[$];

  // Reference state: enabled clocks elapsed since reset (mod one frame).
  int               m_el;
  logic [COL_W-1:0] m_col;
  logic             m_fs;
  int               n_chk = 0;
  int               n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void model_edge();
    int nr;
    if (rst) begin
      m_el = 0; m_col = '0; m_fs = 1'b0;
`ifdef LED_MATRIX_DIM_EN
      m_dq = 0;
`endif
    end else if (en) begin
      m_fs = 1'b0;
      if (m_el % PERIOD == PERIOD - 1) begin
        nr    = (m_el / PERIOD + 1) % NUM_ROWS;
        m_col = pattern[nr*COL_W +: COL_W];
        m_fs  = (nr == 0);
`ifdef LED_MATRIX_DIM_EN
        m_dq  = int'(duty);
`endif
      end
      m_el = (m_el + 1) % FRAME;
    end else begin
      m_fs = 1'b0;
    end
  endfunction

  task automatic push();
    exp_t e;
    int   c;
    bit   on;
    c  = m_el % PERIOD;
    on = en && (c >= GAP_ON) && (c < PERIOD - GAP_OFF);
`ifdef LED_MATRIX_DIM_EN
    on = on && ((c - GAP_ON) < ((PERIOD - GAP_ON - GAP_OFF) * m_dq) / 256);
`endif
    e.row = '1;
    if (on) e.row[m_el / PERIOD] = 1'b0;
    e.col = m_col;
    e.idx = 2'(m_el / PERIOD);
    e.fs  = m_fs;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic n_rst, input logic n_en, input logic [PW-1:0] n_pat);
    tick();
    rst = n_rst; en = n_en; pattern = n_pat;
    push();
  endtask

  // Advance until the model sits at (row r, counter c); caller then sets inputs and pushes.
  task automatic goto(input int r, input int c);
    int k;
    k = 0;
    forever begin
      tick();
      if ((m_el / PERIOD) == r && (m_el % PERIOD) == c) break;
      push();
      k++;
      if (k >= 2000) begin
        n_chk++;
        $display("FAIL goto_bound row=%0d cnt=%0d not reached", r, c);
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("led_row",     32'(led_row),     32'(e.row));
      chk("led_col",     32'(led_col),     32'(e.col));
      chk("row_index",   32'(row_index),   32'(e.idx));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
    end
  end

  initial begin
    // Reset held for three edges with en high.
    step(1'b1, 1'b1, 12'hCBA);
    step(1'b1, 1'b1, 12'hCBA);
    step(1'b0, 1'b1, 12'hCBA);

    // Two full frames of free-running scan.
    repeat (2 * FRAME) step(1'b0, 1'b1, 12'hCBA);

    // Mid-dwell pattern update in row 1.
    goto(1, 8);
    pattern = 12'h555;
    push();
    repeat (PERIOD + 5) step(1'b0, 1'b1, 12'h555);

    // Enable dropped mid-dwell for seven cycles.
    goto(0, 10);
    en = 1'b0;
    push();
    repeat (6) step(1'b0, 1'b0, pattern);
    repeat (PERIOD) step(1'b0, 1'b1, pattern);

    // Reset pulse in the middle of row 2.
    goto(2, 12);
    rst = 1'b1;
    push();
    repeat (2 * FRAME) step(1'b0, 1'b1, 12'hCBA);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [PW-1:0] np;
      np = ($urandom_range(0, 9) == 0) ? PW'($urandom) : pattern;
`ifdef LED_MATRIX_DIM_EN
      if ($urandom_range(0, 19) == 0) duty = 8'($urandom);
`endif
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 85, np);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
Parametrised time-multiplexed LED matrix driver. It is the successor to the fixed 9-row × 8-column scan logic in the board tops. Row count, column width, dwell period and anti-ghost gaps are configurable. A flat pattern bus is latched per row so that mid-row updates never tear. The block sits in board tops between the debug/IO registers and the matrix pins.

Parameters:
NUM_ROWS, 9, number of multiplexed rows (2..16)
COL_W, 8, column bits per row
PERIOD, 27000, clocks per row dwell (1 ms at 27 MHz)
GAP_ON, 100, blank clocks at start of each dwell
GAP_OFF, 2000, blank clocks at end of each dwell
ROW_ACTIVE_LOW, 1, 1 = selected row driven 0, others 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  1 = scan runs; 0 = freeze counters, blank rows
pattern  in  NUM_ROWS*COL_W  row r at bits [r*COL_W +: COL_W]
led_row  out  NUM_ROWS  row select, polarity per ROW_ACTIVE_LOW
led_col  out  COL_W  latched column pattern of current row
row_index  out  $clog2(NUM_ROWS)  current row
frame_start  out  1  one-cycle pulse when row wraps to 0

Behaviour:
- Reset (rst=1 at clk edge, overrides all): counter=0, row_index=0, col latch=0, frame_start=0; led_row all-inactive.
- Reset mid-dwell restarts at row 0, counter 0. First row-0 dwell after reset shows column 0 until the first latch event; frame_start is not pulsed for it.
- Counter: width $clog2(PERIOD).
  - en=1: increments by 1 per clock; at PERIOD-1 it wraps to 0.
  - en=0: holds value.
- Row advance, in the cycle where en=1 and counter==PERIOD-1:
  - row_index <= (row_index==NUM_ROWS-1) ? 0 : row_index+1.
  - col latch <= pattern slice of the next row, sampled that same cycle.
  - frame_start <= 1 iff the next row is 0; otherwise frame_start is 0.
- led_on = en && GAP_ON <= counter < PERIOD-GAP_OFF. Combinational from registered state; no extra latency.
- led_row: bit row_index active iff led_on; all other bits inactive. With ROW_ACTIVE_LOW=1, led_row = all-ones XOR (led_on << row_index).
- led_col: equals the col latch at all times; it is not gated by led_on.
- Pattern changes mid-dwell are invisible until the next row advance.
- en falling mid-dwell: rows blank immediately, counter and row hold, col latch holds. en rising resumes from the held counter value.
- Elaboration check ($error): GAP_ON+GAP_OFF < PERIOD, NUM_ROWS >= 2, COL_W >= 1.

Optional Feature:
LED_MATRIX_DIM_EN
- When defined: adds input duty[7:0], sampled into duty_q at each row advance (reset 0).
  - W = PERIOD-GAP_ON-GAP_OFF.
  - led_on additionally requires (counter-GAP_ON) < (W*duty_q)>>8, computed at 32-bit width.
  - duty_q=0 means never on; duty_q=255 means on for floor(W*255/256) clocks.
- When undefined: no duty port; full window W, identical to the base behaviour.

Decomposition:
- Shared package led_scan_pkg: localparam helpers for counter width and row-index width, plus the default timing constants (27 MHz, 1 ms period, gap values).
- One natural sub-module: led_row_timer (counter, wrap, advance strobe, led_on window, optional duty compare).
- Row/column latch and one-hot decode stay in led_matrix_scan.

Test Plan:
Bench params: PERIOD=20, GAP_ON=2, GAP_OFF=4, NUM_ROWS=3, COL_W=4, ROW_ACTIVE_LOW=1.
- Reset held 3 cycles, en=1 -> led_row=3'b111, led_col=0, row_index=0, frame_start=0 for every reset cycle.
- en=1, pattern=12'hCBA -> within row 0, led_row=3'b110 exactly for counter 2..15 (14 clocks), 3'b111 otherwise.
- After first advance -> row_index=1, led_col=4'hB; after second -> row_index=2, led_col=4'hC; after third -> row_index=0, led_col=4'hA, frame_start=1 for one cycle; pulses repeat every 60 clocks.
- Change pattern to 12'h555 at counter 8 of row 1 -> led_col stays 4'hB until the advance, then row 2 shows 4'h5.
- en=0 at counter 10 for 7 cycles -> led_row=3'b111, counter and row frozen at 10; on resume, the window ends at counter 15 as normal.
- rst pulse at counter 12 of row 2 -> next cycle counter=0, row_index=0, led_col=0, led_row=3'b111. With LED_MATRIX_DIM_EN and duty=128 -> on for counter 2..8 (7 clocks).
